// File: rtl/traffic_actuated_scheduler_if.sv
// Signal bundle between the actuated scheduler and its detectors, preemption
// receiver and signal heads. The scheduler takes the slave side.
interface traffic_actuated_scheduler_if;
  logic       tick;
  logic       det_n, det_s, det_e, det_w;
  logic       preempt_req, preempt_ew;
  logic [2:0] ns_light, ew_light, phase;
  logic       call_ns, call_ew, preempt_active;

  modport master (
    output tick, det_n, det_s, det_e, det_w, preempt_req, preempt_ew,
    input  ns_light, ew_light, phase, call_ns, call_ew, preempt_active
  );

  modport slave (
    input  tick, det_n, det_s, det_e, det_w, preempt_req, preempt_ew,
    output ns_light, ew_light, phase, call_ns, call_ew, preempt_active
  );
endinterface

// File: rtl/traffic_actuated_scheduler.sv
// Demand-actuated two-phase (NS/EW) intersection scheduler with min/gap/max
// green timing, yellow and all-red clearance, and emergency preemption.
module traffic_actuated_scheduler #(
  parameter int CNT_W     = 6,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int GAP       = 3,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  traffic_actuated_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    STARTUP   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    NS_CLEAR  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    EW_CLEAR  = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] MIN_T     = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_T     = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] GAP_T     = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] YELLOW_T  = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] ALL_RED_T = CNT_W'(ALL_RED);

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, gap;
  logic             call_ns, call_ew;
  logic             req_q, ew_q;
  logic             pre_ns, pre_ew;
  logic             det_ns, det_ew;
  logic             enter_ns, enter_ew, served_det;
  logic [2:0]       ns_light, ew_light;

  assign det_ns = bus.det_n | bus.det_s;
  assign det_ew = bus.det_e | bus.det_w;
  assign pre_ew = req_q & ew_q;
  assign pre_ns = req_q & ~ew_q;

  assign enter_ns   = (state_next == NS_GREEN) && (state != NS_GREEN);
  assign enter_ew   = (state_next == EW_GREEN) && (state != EW_GREEN);
  assign served_det = ((state == NS_GREEN) && det_ns) || ((state == EW_GREEN) && det_ew);

  // NOTE: every signal driven here gets its default before the case, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      STARTUP:
        if (timer >= ALL_RED_T) state_next = pre_ew ? EW_GREEN : NS_GREEN;
      NS_GREEN:
        if (pre_ew || (!pre_ns && (timer >= MIN_T) && call_ew &&
                       ((gap >= GAP_T) || (timer >= MAX_T))))
          state_next = NS_YELLOW;
      NS_YELLOW:
        if (timer >= YELLOW_T) state_next = NS_CLEAR;
      NS_CLEAR:
        if (timer >= ALL_RED_T) state_next = EW_GREEN;
      EW_GREEN:
        if (pre_ns || (!pre_ew && (timer >= MIN_T) && call_ns &&
                       ((gap >= GAP_T) || (timer >= MAX_T))))
          state_next = EW_YELLOW;
      EW_YELLOW:
        if (timer >= YELLOW_T) state_next = EW_CLEAR;
      EW_CLEAR:
        if (timer >= ALL_RED_T) state_next = NS_GREEN;
      default:
        state_next = STARTUP;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= STARTUP;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      gap     <= '0;
      call_ns <= 1'b0;
      call_ew <= 1'b0;
      req_q   <= 1'b0;
      ew_q    <= 1'b0;
    end else begin
      req_q <= bus.preempt_req;
      if (bus.preempt_req) ew_q <= bus.preempt_ew;

      if (state_next != state)                 timer <= '0;
      else if (bus.tick && (timer != CNT_SAT)) timer <= timer + 1'b1;

      if (enter_ns || enter_ew || served_det) gap <= '0;
      else if (bus.tick && (gap != CNT_SAT))  gap <= gap + 1'b1;

      // Clearing on green entry takes priority over a detection in the same cycle.
      if (enter_ns)                            call_ns <= 1'b0;
      else if (det_ns && (state != NS_GREEN))  call_ns <= 1'b1;
      if (enter_ew)                            call_ew <= 1'b0;
      else if (det_ew && (state != EW_GREEN))  call_ew <= 1'b1;
    end
  end

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    case (state)
      NS_GREEN:  ns_light = GRN;
      NS_YELLOW: ns_light = YEL;
      EW_GREEN:  ew_light = GRN;
      EW_YELLOW: ew_light = YEL;
      default: ;
    endcase
  end

  assign bus.ns_light       = ns_light;
  assign bus.ew_light       = ew_light;
  assign bus.phase          = state;
  assign bus.call_ns        = call_ns;
  assign bus.call_ew        = call_ew;
  assign bus.preempt_active = req_q;

endmodule

// File: tb/tb_traffic_actuated_scheduler.sv
// Scenario bench for traffic_actuated_scheduler: a phase-sequence scoreboard
// plus per-scenario inline checks of lights, calls and preemption status.
module tb_traffic_actuated_scheduler;

  localparam int TICK_DIV = 4;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct {
    int phase;
    int ticks;   // ticks spent in the previous phase; -1 = not checked
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  traffic_actuated_scheduler_if bus();

  traffic_actuated_scheduler #(
    .CNT_W(6), .MIN_GREEN(5), .MAX_GREEN(20), .GAP(3), .YELLOW(3), .ALL_RED(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ticks_in_phase = 0;
  int         tick_cnt = 0;
  bit         tick_en  = 1'b0;
  logic [2:0] last_phase = 3'd0;

  function automatic logic [2:0] exp_ns_light(input int p);
    case (p)
      1:       return GRN;
      2:       return YEL;
      default: return RED;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew_light(input int p);
    case (p)
      4:       return GRN;
      5:       return YEL;
      default: return RED;
    endcase
  endfunction

  task automatic expect_phase(input int p, input int t);
    exp_t e;
    e.phase = p;
    e.ticks = t;
    sb.push_back(e);
  endtask

  // Scoreboard side: runs once per negedge, compares every phase change
  // against the oldest expected entry and tracks ticks spent in the phase.
  task automatic monitor();
    logic [2:0] cur;
    exp_t       e;
    if (reset) begin
      last_phase     = 3'd0;
      ticks_in_phase = 0;
      return;
    end
    cur = bus.phase;
    if (cur != last_phase) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_phase: phase %0d -> %0d after %0d ticks, no change expected",
                 last_phase, cur, ticks_in_phase);
      end else begin
        e = sb.pop_front();
        if ((int'(cur) != e.phase) || ((e.ticks >= 0) && (ticks_in_phase != e.ticks))) begin
          n_fail++;
          $display("FAIL phase_seq: got phase %0d after %0d ticks, required phase %0d after %0d ticks",
                   cur, ticks_in_phase, e.phase, e.ticks);
        end
        n_checks++;
        if ((bus.ns_light !== exp_ns_light(e.phase)) || (bus.ew_light !== exp_ew_light(e.phase))) begin
          n_fail++;
          $display("FAIL phase_lights: phase %0d ns=%b ew=%b, required ns=%b ew=%b",
                   e.phase, bus.ns_light, bus.ew_light, exp_ns_light(e.phase), exp_ew_light(e.phase));
        end
      end
      last_phase     = cur;
      ticks_in_phase = 0;
    end else if (bus.tick) begin
      ticks_in_phase++;
    end
    n_checks++;
    if (((bus.ns_light == GRN) && ((bus.ew_light == GRN) || (bus.ew_light == YEL))) ||
        ((bus.ew_light == GRN) && (bus.ns_light == YEL))) begin
      n_fail++;
      $display("FAIL light_conflict: ns=%b ew=%b, required no green/green or green/yellow",
               bus.ns_light, bus.ew_light);
    end
  endtask

  task automatic drive_tick();
    if (!tick_en) begin
      tick_cnt = 0;
      bus.tick = 1'b0;
    end else begin
      tick_cnt++;
      if (tick_cnt == TICK_DIV) begin
        tick_cnt = 0;
        bus.tick = 1'b1;
      end else begin
        bus.tick = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    drive_tick();
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      step();
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected phase entries pending after %0d clk, phase=%0d, required 0 pending",
               sb.size(), budget, bus.phase);
      sb.delete();
    end
  endtask

  task automatic wait_ticks(input int k);
    int n = 0;
    while ((ticks_in_phase != k) && (n < 400)) begin
      step();
      n++;
    end
    n_checks++;
    if (ticks_in_phase != k) begin
      n_fail++;
      $display("FAIL wait_ticks: ticks_in_phase=%0d, required %0d", ticks_in_phase, k);
    end
  endtask

  task automatic clear_inputs();
    bus.det_n = 1'b0;
    bus.det_s = 1'b0;
    bus.det_e = 1'b0;
    bus.det_w = 1'b0;
    bus.preempt_req = 1'b0;
    bus.preempt_ew  = 1'b0;
  endtask

  task automatic do_reset();
    sb.delete();
    tick_en = 1'b0;
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_startup();
    do_reset();
    expect_phase(1, 1);
    tick_en = 1'b1;
    drain(100);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: bus.det_n = 1'b1;
      1: bus.det_s = 1'b1;
      2: bus.det_e = 1'b1;
      default: bus.det_w = 1'b1;
    endcase
    step();
    case (which)
      0: bus.det_n = 1'b0;
      1: bus.det_s = 1'b0;
      2: bus.det_e = 1'b0;
      default: bus.det_w = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    bus.tick = 1'b0;
    clear_inputs();
    tick_en = 1'b0;
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.phase !== 3'd0) begin
      n_fail++; $display("FAIL reset_phase: got %0d, required 0", bus.phase);
    end
    n_checks++;
    if ((bus.ns_light !== RED) || (bus.ew_light !== RED)) begin
      n_fail++; $display("FAIL reset_lights: ns=%b ew=%b, required 100/100", bus.ns_light, bus.ew_light);
    end
    n_checks++;
    if ((bus.call_ns !== 1'b0) || (bus.call_ew !== 1'b0) || (bus.preempt_active !== 1'b0)) begin
      n_fail++; $display("FAIL reset_flags: call_ns=%b call_ew=%b preempt_active=%b, required 0/0/0",
                         bus.call_ns, bus.call_ew, bus.preempt_active);
    end
    reset = 1'b0;
  endtask

  task automatic test_rest_in_green();
    do_startup();
    for (int i = 0; i < 100 * TICK_DIV; i++) step();
    n_checks++;
    if ((bus.phase !== 3'd1) || (bus.ns_light !== GRN) || (bus.ew_light !== RED)) begin
      n_fail++; $display("FAIL rest_in_green: phase=%0d ns=%b ew=%b, required 1/001/100",
                         bus.phase, bus.ns_light, bus.ew_light);
    end
    n_checks++;
    if ((bus.call_ns !== 1'b0) || (bus.call_ew !== 1'b0)) begin
      n_fail++; $display("FAIL rest_calls: call_ns=%b call_ew=%b, required 0/0", bus.call_ns, bus.call_ew);
    end
  endtask

  task automatic test_min_green_call();
    do_startup();
    wait_ticks(2);
    pulse(2);
    n_checks++;
    if (bus.call_ew !== 1'b1) begin
      n_fail++; $display("FAIL call_ew_latch: got %b, required 1", bus.call_ew);
    end
    expect_phase(2, 5);
    expect_phase(3, 3);
    expect_phase(4, 1);
    drain(200);
    n_checks++;
    if (bus.call_ew !== 1'b0) begin
      n_fail++; $display("FAIL call_ew_clear: got %b, required 0", bus.call_ew);
    end
  endtask

  task automatic test_max_out();
    do_startup();
    bus.det_n = 1'b1;
    wait_ticks(2);
    pulse(2);
    expect_phase(2, 20);
    expect_phase(3, 3);
    expect_phase(4, 1);
    drain(400);
    n_checks++;
    if (bus.call_ns !== 1'b1) begin
      n_fail++; $display("FAIL max_out_call_ns: got %b, required 1", bus.call_ns);
    end
    bus.det_n = 1'b0;
    expect_phase(5, 5);
    expect_phase(6, 3);
    expect_phase(1, 1);
    drain(200);
  endtask

  task automatic test_gap_out();
    do_startup();
    wait_ticks(1);
    pulse(2);
    for (int k = 2; k <= 10; k += 2) begin
      wait_ticks(k);
      pulse(1);
    end
    expect_phase(2, 13);
    expect_phase(3, 3);
    expect_phase(4, 1);
    drain(200);
  endtask

  task automatic test_preempt();
    do_startup();
    wait_ticks(1);
    bus.preempt_req = 1'b1;
    bus.preempt_ew  = 1'b1;
    bus.det_n       = 1'b1;
    expect_phase(2, 1);
    expect_phase(3, 3);
    expect_phase(4, 1);
    step();
    n_checks++;
    if ((bus.phase !== 3'd1) || (bus.preempt_active !== 1'b1)) begin
      n_fail++; $display("FAIL preempt_edge1: phase=%0d active=%b, required 1/1", bus.phase, bus.preempt_active);
    end
    step();
    n_checks++;
    if (bus.phase !== 3'd2) begin
      n_fail++; $display("FAIL preempt_edge2: phase=%0d, required 2", bus.phase);
    end
    drain(100);
    for (int i = 0; i < 50 * TICK_DIV; i++) step();
    n_checks++;
    if ((bus.phase !== 3'd4) || (bus.preempt_active !== 1'b1) || (bus.call_ns !== 1'b1)) begin
      n_fail++; $display("FAIL preempt_hold: phase=%0d active=%b call_ns=%b, required 4/1/1",
                         bus.phase, bus.preempt_active, bus.call_ns);
    end
    expect_phase(5, -1);
    bus.preempt_req = 1'b0;
    step();
    n_checks++;
    if ((bus.phase !== 3'd4) || (bus.preempt_active !== 1'b0)) begin
      n_fail++; $display("FAIL preempt_release: phase=%0d active=%b, required 4/0", bus.phase, bus.preempt_active);
    end
    step();
    n_checks++;
    if (bus.phase !== 3'd5) begin
      n_fail++; $display("FAIL resume_rules: phase=%0d, required 5", bus.phase);
    end
    expect_phase(6, 3);
    expect_phase(1, 1);
    drain(100);
    bus.det_n = 1'b0;
  endtask

  task automatic test_startup_preempt();
    do_reset();
    bus.preempt_req = 1'b1;
    bus.preempt_ew  = 1'b1;
    expect_phase(4, 1);
    tick_en = 1'b1;
    drain(100);
    n_checks++;
    if ((bus.preempt_active !== 1'b1) || (bus.ew_light !== GRN) || (bus.ns_light !== RED)) begin
      n_fail++; $display("FAIL startup_preempt: active=%b ns=%b ew=%b, required 1/100/001",
                         bus.preempt_active, bus.ns_light, bus.ew_light);
    end
    bus.preempt_req = 1'b0;
    for (int i = 0; i < 10 * TICK_DIV; i++) step();
    n_checks++;
    if ((bus.phase !== 3'd4) || (bus.preempt_active !== 1'b0)) begin
      n_fail++; $display("FAIL startup_preempt_rest: phase=%0d active=%b, required 4/0",
                         bus.phase, bus.preempt_active);
    end
  endtask

  task automatic test_reset_mid();
    do_startup();
    pulse(2);
    expect_phase(2, 5);
    expect_phase(3, 3);
    expect_phase(4, 1);
    drain(200);
    pulse(0);
    expect_phase(5, 5);
    drain(100);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ((bus.ns_light !== RED) || (bus.ew_light !== RED) || (bus.phase !== 3'd0)) begin
      n_fail++; $display("FAIL async_reset: phase=%0d ns=%b ew=%b, required 0/100/100",
                         bus.phase, bus.ns_light, bus.ew_light);
    end
    n_checks++;
    if ((bus.call_ns !== 1'b0) || (bus.call_ew !== 1'b0)) begin
      n_fail++; $display("FAIL async_reset_calls: call_ns=%b call_ew=%b, required 0/0",
                         bus.call_ns, bus.call_ew);
    end
    tick_en = 1'b0;
    step();
    step();
    reset = 1'b0;
    expect_phase(1, 1);
    tick_en = 1'b1;
    drain(100);
    n_checks++;
    if ((bus.ns_light !== GRN) || (bus.ew_light !== RED)) begin
      n_fail++; $display("FAIL restart: ns=%b ew=%b, required 001/100", bus.ns_light, bus.ew_light);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_rest_in_green();
    test_min_green_call();
    test_max_out();
    test_gap_out();
    test_preempt();
    test_startup_preempt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_actuated_scheduler.md
Name: traffic_actuated_scheduler

Overview:
Demand-actuated phase scheduler for a 4-way intersection with two conflicting phase groups: NS (north+south) and EW (east+west).
- Latches vehicle calls from the approach detectors.
- Times green using minimum green, gap-out and max-out rules, then sequences yellow and all-red clearance.
- Supports emergency preemption.
- Its light outputs drive the per-approach signal heads.
- All timing is in units of an external `tick` enable; the block is clocked every `clk` cycle.

Parameters:
- CNT_W, 6, width of the phase and gap timers.
- MIN_GREEN, 5, minimum green in ticks.
- MAX_GREEN, 20, maximum green in ticks when an opposing call is waiting.
- GAP, 3, ticks without served-direction detection that end green.
- YELLOW, 3, yellow duration in ticks.
- ALL_RED, 1, all-red clearance duration in ticks.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  timebase enable; one-cycle pulse
- det_n, det_s, det_e, det_w  in  1 each  vehicle detector levels
- preempt_req  in  1  emergency preemption request, level
- preempt_ew  in  1  preemption target direction: 1 = EW, 0 = NS; sampled while preempt_req = 1
- ns_light  out  3  NS head, one-hot: red = 100, yellow = 010, green = 001
- ew_light  out  3  EW head, same encoding
- phase  out  3  current state encoding
- call_ns, call_ew  out  1 each  latched call status
- preempt_active  out  1  high while a preemption is being served

Behaviour:
- Interface: reset is asynchronous, active-high; the clock is `clk`.
- All outputs are registered or decoded from registered state only.

Reset values:
- phase = STARTUP (0).
- ns_light = ew_light = 100.
- call_ns = call_ew = 0, preempt_active = 0.
- Timers = 0.
- A reset asserted mid-operation forces these values immediately, regardless of state.

State encoding:
- STARTUP = 0, NS_GREEN = 1, NS_YELLOW = 2, NS_CLEAR = 3, EW_GREEN = 4, EW_YELLOW = 5, EW_CLEAR = 6.
- Codes 7 and any other illegal value go to STARTUP on the next edge.

Lights:
- Served head is green in its X_GREEN state and yellow in X_YELLOW.
- Every other head is red, including both heads in STARTUP and in X_CLEAR.
- Both heads green at once, or one green while the other is yellow, is illegal under all conditions.

Timers:
- `timer` clears to 0 on every state change.
- Otherwise `timer` increments on each tick and saturates at 2^CNT_W - 1.
- `gap` clears on any clk where a served-direction detector is high, or on entry to green.
- Otherwise `gap` increments on tick and saturates.

Calls:
- call_ns is set on any clk with det_n | det_s while not in NS_GREEN. call_ew is set likewise with det_e | det_w while not in EW_GREEN.
- A call is cleared on the edge that enters its green; clear wins over a simultaneous set.

Transitions (evaluated every clk edge using registered timer/gap; the exit edge is the first edge at which the condition holds):
- STARTUP -> NS_GREEN when timer >= ALL_RED.
  - Exception: if preempt_req = 1 and preempt_ew = 1, go to EW_GREEN instead.
- X_GREEN -> X_YELLOW on either of:
  - preemption pending for the opposite direction, with no MIN_GREEN wait; or
  - no preemption for X, and timer >= MIN_GREEN, and the opposite call = 1, and (gap >= GAP or timer >= MAX_GREEN).
- With no opposing call, green rests indefinitely (rest-in-green).
- While preemption for X is active, X_GREEN is held and the min/max/gap rules are ignored.
- X_YELLOW -> X_CLEAR when timer >= YELLOW.
- X_CLEAR -> opposite GREEN when timer >= ALL_RED.
- Yellow and all-red are never truncated by preemption or by any input.

Preemption:
- preempt_req and preempt_ew are registered once, giving 1-cycle sampling latency.
- preempt_active = 1 from the first edge where the sampled request is high until the sampled request drops.
- Changing preempt_ew during an active preemption re-targets it: a held green ends via the normal yellow and clear sequence.
- After release, normal actuated rules resume with the current timer value (no restart).

Test Plan:
- Reset, tick every 4 clk, no detectors -> STARTUP for 1 tick, then NS_GREEN; NS stays green (001) and EW red (100) for 100 ticks; calls stay 0.
- NS_GREEN, 1-clk det_e pulse at timer = 2, det_n/det_s low -> call_ew = 1; NS_YELLOW entered at timer = 5; 3 ticks yellow; 1 tick NS_CLEAR with both heads 100; EW_GREEN; call_ew = 0 on entry.
- det_n held high, call_ew set -> NS green ends at timer = 20 (max-out); phase sequence 1 -> 2 -> 3 -> 4.
- det_s pulsed every 2 ticks until timer = 10 then low, call_ew set -> gap-out, yellow entered at timer = 13.
- NS_GREEN at timer = 1, preempt_req = 1 with preempt_ew = 1 -> NS_YELLOW on the 2nd edge after request; full 3-tick yellow and 1-tick clear; EW_GREEN held for 50 ticks despite call_ns; preempt_active = 1 throughout; after release, gap/max rules resume.
- reset asserted mid EW_YELLOW -> both heads 100 with no clk edge, phase = 0, calls cleared; after release, startup sequence repeats.
